// File: rtl/multi_timer_if.sv
// Bridge-bus connection for multi_timer: word address, write strobe and data in both directions.
// The master drives address/write data; the timer answers with combinational read data.
interface multi_timer_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W+1:2] ADD_I;
   logic              WE_I;
   logic [31:0]       DAT_I;
   logic [31:0]       DAT_O;

   modport master (output ADD_I, output WE_I, output DAT_I, input DAT_O);
   modport slave  (input ADD_I, input WE_I, input DAT_I, output DAT_O);
endinterface

// File: rtl/multi_timer.sv
// NCH independent down-counter channels sharing one prescaler, with W1C pending flags
// and a single masked interrupt line.
module multi_timer #(
   parameter int NCH    = 2,
   parameter int WIDTH  = 32,
   parameter int PSC_W  = 16,
   parameter int ADDR_W = 4
) (
   input  logic           CLK_I,
   input  logic           RST_I,
   multi_timer_if.slave   bus,
   output logic           IRQ,
   output logic [NCH-1:0] TOUT
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_EXPIRE} chState_t;

   logic [PSC_W-1:0] pscCnt_q, pscCnt_d;
   logic [PSC_W-1:0] prescale_q;
   logic             tick;
   logic             wrPsc;
   logic             wrStatus;

   logic [NCH-1:0]   pendV;
   logic [NCH-1:0]   imV;
   logic [NCH-1:0]   enV;
   logic [1:0]       modeV   [NCH];
   logic [WIDTH-1:0] presetV [NCH];
   logic [WIDTH-1:0] countV  [NCH];
   logic [31:0]      rdData;

   assign wrPsc    = bus.WE_I && (bus.ADD_I == ADDR_W'(4*NCH+1));
   assign wrStatus = bus.WE_I && (bus.ADD_I == ADDR_W'(4*NCH));
   assign tick     = (pscCnt_q == prescale_q);

   always_comb begin
      pscCnt_d = pscCnt_q + PSC_W'(1);
      if (wrPsc || tick) pscCnt_d = '0;
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         pscCnt_q   <= '0;
         prescale_q <= '0;
      end else begin
         pscCnt_q <= pscCnt_d;
         if (wrPsc) prescale_q <= bus.DAT_I[PSC_W-1:0];
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : gCh
      chState_t         state_q;
      logic [WIDTH-1:0] count_q;
      logic [WIDTH-1:0] preset_q;
      logic             en_q;
      logic [1:0]       mode_q;
      logic             im_q;
      logic             pend_q;
      logic             tout_q;
      logic             wrCtrl;
      logic             wrPreset;
      logic             enEff;
      logic             autoRestart;

      assign wrCtrl      = bus.WE_I && (bus.ADD_I == ADDR_W'(4*c));
      assign wrPreset    = bus.WE_I && (bus.ADD_I == ADDR_W'(4*c+1));
      // A CTRL write takes effect on the FSM at the same edge it is written.
      assign enEff       = wrCtrl ? bus.DAT_I[0] : en_q;
      assign autoRestart = (mode_q == 2'b01) || (mode_q == 2'b10);

      always_ff @(posedge CLK_I or posedge RST_I) begin
         if (RST_I) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            preset_q <= '0;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            tout_q   <= 1'b0;
         end else begin
            // Expiry side effects happen even if EN is being cleared on this edge.
            if (state_q == ST_EXPIRE) begin
               pend_q <= 1'b1;
               if (mode_q == 2'b10) tout_q <= ~tout_q;
               if (!autoRestart) en_q <= 1'b0;
            end else if (wrStatus && bus.DAT_I[c]) begin
               pend_q <= 1'b0;
            end

            if (wrCtrl) begin
               en_q   <= bus.DAT_I[0];
               mode_q <= bus.DAT_I[2:1];
               im_q   <= bus.DAT_I[3];
            end
            if (wrPreset) preset_q <= bus.DAT_I[WIDTH-1:0];

            if (!enEff) begin
               state_q <= ST_IDLE;
            end else begin
               unique case (state_q)
                  ST_IDLE: state_q <= ST_LOAD;
                  ST_LOAD: begin
                     count_q <= preset_q;
                     state_q <= ST_CNT;
                  end
                  ST_CNT: begin
                     if (count_q == '0) begin
                        state_q <= ST_EXPIRE;
                     end else if (tick) begin
                        count_q <= count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) state_q <= ST_EXPIRE;
                     end
                  end
                  ST_EXPIRE: state_q <= autoRestart ? ST_LOAD : ST_IDLE;
                  default: state_q <= ST_IDLE;
               endcase
            end
         end
      end

      assign pendV[c]   = pend_q;
      assign imV[c]     = im_q;
      assign enV[c]     = en_q;
      assign modeV[c]   = mode_q;
      assign presetV[c] = preset_q;
      assign countV[c]  = count_q;
      assign TOUT[c]    = tout_q;
   end

   assign IRQ = |(pendV & imV);

   always_comb begin
      rdData = '0;
      for (int c = 0; c < NCH; c++) begin
         if (bus.ADD_I == ADDR_W'(4*c))   rdData = {28'b0, imV[c], modeV[c], enV[c]};
         if (bus.ADD_I == ADDR_W'(4*c+1)) rdData = 32'(presetV[c]);
         if (bus.ADD_I == ADDR_W'(4*c+2)) rdData = 32'(countV[c]);
      end
      if (bus.ADD_I == ADDR_W'(4*NCH))   rdData = 32'(pendV);
      if (bus.ADD_I == ADDR_W'(4*NCH+1)) rdData = 32'(prescale_q);
   end

   assign bus.DAT_O = rdData;

endmodule

// File: tb/tb_multi_timer.sv
// Directed plus randomized bench for multi_timer (NCH=2, WIDTH=32, PSC_W=16, ADDR_W=4).
// Expiry edges are predicted arithmetically from PRESET, PRESCALE and the prescaler phase.
module tb_multi_timer;

   localparam logic [3:0] A_CTRL0  = 4'd0;
   localparam logic [3:0] A_PRE0   = 4'd1;
   localparam logic [3:0] A_CNT0   = 4'd2;
   localparam logic [3:0] A_CTRL1  = 4'd4;
   localparam logic [3:0] A_PRE1   = 4'd5;
   localparam logic [3:0] A_STATUS = 4'd8;
   localparam logic [3:0] A_PSC    = 4'd9;

   logic       CLK_I;
   logic       RST_I;
   logic       IRQ;
   logic [1:0] TOUT;

   int tests;
   int failures;
   int cyc;

   multi_timer_if #(.ADDR_W(4)) bus ();

   multi_timer #(.NCH(2), .WIDTH(32), .PSC_W(16), .ADDR_W(4)) dut (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .bus   (bus),
      .IRQ   (IRQ),
      .TOUT  (TOUT)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   always @(posedge CLK_I) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
      bus.ADD_I = addr;
      bus.WE_I  = 1'b1;
      bus.DAT_I = data;
      step();
      bus.WE_I  = 1'b0;
      bus.DAT_I = '0;
   endtask

   task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
      bus.ADD_I = addr;
      bus.WE_I  = 1'b0;
      #1;
      data = bus.DAT_O;
   endtask

   task automatic waitUntil(input int edgeNum);
      int guard;
      guard = 0;
      while (cyc < edgeNum && guard < 5000) begin
         step();
         guard++;
      end
      if (cyc != edgeNum) checkOutput("waitUntil", 32'(cyc), 32'(edgeNum));
   endtask

   // Edge on which pending rises when the channel entered LOAD after edge L.
   // Ticks fall on edges t > w with (t - w) a multiple of p+1.
   function automatic int pendEdge(input int L, input int n, input int w, input int p);
      int f;
      if (n == 0) return L + 3;
      f = L + 2;
      while (((f - w) % (p + 1)) != 0) f++;
      return f + (n - 1) * (p + 1) + 1;
   endfunction

   logic [31:0] rd;
   logic [1:0]  toutExp;
   int          e0, w, x, x1, guardT;
   int          n, p, ch;
   logic [1:0]  md;

   initial begin
      tests    = 0;
      failures = 0;
      cyc      = 0;
      toutExp  = 2'b00;
      RST_I     = 1'b1;
      bus.ADD_I = '0;
      bus.WE_I  = 1'b0;
      bus.DAT_I = '0;
      step();
      step();
      RST_I = 1'b0;

      checkOutput("rst_irq", 32'(IRQ), 32'd0);
      checkOutput("rst_tout", 32'(TOUT), 32'd0);
      readReg(A_CTRL0, rd);  checkOutput("rst_ctrl0", rd, 32'd0);
      readReg(A_PRE0, rd);   checkOutput("rst_pre0", rd, 32'd0);
      readReg(A_CNT0, rd);   checkOutput("rst_cnt0", rd, 32'd0);
      readReg(A_STATUS, rd); checkOutput("rst_status", rd, 32'd0);
      readReg(A_PSC, rd);    checkOutput("rst_psc", rd, 32'd0);

      // One-shot on channel 0
      applyStimulus(A_PRE0, 32'd20);
      applyStimulus(A_CTRL0, 32'b1001);
      e0 = cyc;
      waitUntil(e0 + 1);
      readReg(A_CNT0, rd);   checkOutput("os_cnt_e1", rd, 32'd20);
      waitUntil(e0 + 21);
      readReg(A_CNT0, rd);   checkOutput("os_cnt_e21", rd, 32'd0);
      checkOutput("os_irq_e21", 32'(IRQ), 32'd0);
      step();
      checkOutput("os_irq_e22", 32'(IRQ), 32'd1);
      readReg(A_STATUS, rd); checkOutput("os_status", rd, 32'd1);
      readReg(A_CTRL0, rd);  checkOutput("os_ctrl", rd, 32'b1000);
      step();
      readReg(A_CNT0, rd);   checkOutput("os_cnt_hold", rd, 32'd0);
      applyStimulus(A_STATUS, 32'd1);
      checkOutput("os_irq_clr", 32'(IRQ), 32'd0);

      // Auto-reload on channel 1, W1C races
      applyStimulus(A_PRE1, 32'd5);
      applyStimulus(A_CTRL1, 32'b1011);
      e0 = cyc;
      waitUntil(e0 + 6);
      readReg(A_STATUS, rd); checkOutput("ar_pre", rd, 32'd0);
      step();
      readReg(A_STATUS, rd); checkOutput("ar_set1", rd, 32'd2);
      checkOutput("ar_irq", 32'(IRQ), 32'd1);
      waitUntil(e0 + 12);
      applyStimulus(A_STATUS, 32'd2);
      readReg(A_STATUS, rd); checkOutput("ar_w1c_early", rd, 32'd0);
      step();
      readReg(A_STATUS, rd); checkOutput("ar_set2", rd, 32'd2);
      waitUntil(e0 + 20);
      applyStimulus(A_STATUS, 32'd2);
      readReg(A_STATUS, rd); checkOutput("ar_w1c_same_edge", rd, 32'd2);
      applyStimulus(A_CTRL1, 32'd0);
      step();
      applyStimulus(A_STATUS, 32'd3);
      readReg(A_STATUS, rd); checkOutput("ar_cleanup", rd, 32'd0);

      // Square wave on channel 0, prescale 1, masked
      applyStimulus(A_PSC, 32'd1);
      w = cyc;
      applyStimulus(A_PRE0, 32'd3);
      applyStimulus(A_CTRL0, 32'b0101);
      e0 = cyc;
      x1 = pendEdge(e0, 3, w, 1);
      waitUntil(x1 - 1);
      checkOutput("sq_tout_before", 32'(TOUT), 32'd0);
      step();
      checkOutput("sq_tout_t1", 32'(TOUT), 32'd1);
      readReg(A_STATUS, rd); checkOutput("sq_status", rd, 32'd1);
      checkOutput("sq_irq_masked", 32'(IRQ), 32'd0);
      waitUntil(x1 + 7);
      checkOutput("sq_tout_hold", 32'(TOUT), 32'd1);
      step();
      checkOutput("sq_tout_t2", 32'(TOUT), 32'd0);
      applyStimulus(A_CTRL0, 32'd0);
      applyStimulus(A_PSC, 32'd0);
      applyStimulus(A_STATUS, 32'd3);

      // Disable mid-count and reprogram
      applyStimulus(A_PRE0, 32'd15);
      applyStimulus(A_CTRL0, 32'b0001);
      e0 = cyc;
      waitUntil(e0 + 7);
      readReg(A_CNT0, rd);   checkOutput("dis_cnt9", rd, 32'd9);
      applyStimulus(A_CTRL0, 32'd0);
      readReg(A_CNT0, rd);   checkOutput("dis_hold_a", rd, 32'd9);
      step();
      step();
      readReg(A_CNT0, rd);   checkOutput("dis_hold_b", rd, 32'd9);
      applyStimulus(A_CNT0, 32'h55);
      readReg(A_CNT0, rd);   checkOutput("cnt_write_ignored", rd, 32'd9);
      applyStimulus(A_PRE0, 32'd4);
      applyStimulus(A_CTRL0, 32'b0001);
      readReg(A_CNT0, rd);   checkOutput("reprog_load", rd, 32'd9);
      step();
      readReg(A_CNT0, rd);   checkOutput("reprog_cnt4", rd, 32'd4);
      applyStimulus(A_CTRL0, 32'd0);
      step();
      applyStimulus(A_STATUS, 32'd3);

      // Both channels PRESET=0 auto-reload, aligned expiries
      applyStimulus(A_PRE0, 32'd0);
      applyStimulus(A_PRE1, 32'd0);
      applyStimulus(A_CTRL1, 32'b1011);
      e0 = cyc;
      waitUntil(e0 + 2);
      applyStimulus(A_CTRL0, 32'b1011);
      applyStimulus(A_STATUS, 32'd3);
      waitUntil(e0 + 5);
      readReg(A_STATUS, rd); checkOutput("p0_clear", rd, 32'd0);
      step();
      readReg(A_STATUS, rd); checkOutput("p0_both", rd, 32'd3);
      applyStimulus(A_STATUS, 32'd3);
      step();
      readReg(A_STATUS, rd); checkOutput("p0_gap", rd, 32'd0);
      step();
      readReg(A_STATUS, rd); checkOutput("p0_period3", rd, 32'd3);
      readReg(4'd3, rd);     checkOutput("rsv_word3", rd, 32'd0);
      readReg(4'd7, rd);     checkOutput("rsv_word7", rd, 32'd0);
      readReg(4'd10, rd);    checkOutput("unmapped10", rd, 32'd0);
      readReg(4'd15, rd);    checkOutput("unmapped15", rd, 32'd0);
      applyStimulus(A_CTRL0, 32'd0);
      applyStimulus(A_CTRL1, 32'd0);
      step();
      applyStimulus(A_STATUS, 32'd3);

      // Randomized auto-reload / square-wave runs against the arithmetic model
      for (int it = 0; it < 8; it++) begin
         n  = int'($urandom_range(0, 10));
         p  = int'($urandom_range(0, 3));
         ch = int'($urandom_range(0, 1));
         md = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
         applyStimulus(A_PSC, 32'(p));
         w = cyc;
         applyStimulus(4'(4*ch + 1), 32'(n));
         applyStimulus(4'(4*ch), {28'b0, 1'b1, md, 1'b1});
         x = cyc;
         for (int k = 0; k < 3; k++) begin
            x = pendEdge(x, n, w, p);
            waitUntil(x - 1);
            readReg(A_STATUS, rd); checkOutput("rnd_pre", 32'(rd[ch]), 32'd0);
            step();
            readReg(A_STATUS, rd); checkOutput("rnd_set", 32'(rd[ch]), 32'd1);
            if (md == 2'b10) toutExp[ch] = ~toutExp[ch];
            checkOutput("rnd_tout", 32'(TOUT), 32'(toutExp));
            checkOutput("rnd_irq", 32'(IRQ), 32'd1);
            applyStimulus(A_STATUS, 32'(1 << ch));
         end
         applyStimulus(4'(4*ch), 32'd0);
         step();
         applyStimulus(A_STATUS, 32'd3);
      end
      applyStimulus(A_PSC, 32'd0);

      // Asynchronous reset mid-count with IRQ high
      applyStimulus(A_PRE0, 32'd50);
      applyStimulus(A_CTRL0, 32'b1011);
      applyStimulus(A_PRE1, 32'd0);
      applyStimulus(A_CTRL1, 32'b1101);
      guardT = 0;
      while (!(IRQ === 1'b1 && TOUT[1] !== toutExp[1]) && guardT < 20) begin
         step();
         guardT++;
      end
      checkOutput("rst_pre_irq", 32'(IRQ), 32'd1);
      readReg(A_CNT0, rd);
      checkOutput("rst_pre_counting", 32'(rd != 32'd0), 32'd1);
      RST_I = 1'b1;
      #1;
      checkOutput("arst_irq", 32'(IRQ), 32'd0);
      checkOutput("arst_tout", 32'(TOUT), 32'd0);
      readReg(A_CNT0, rd);   checkOutput("arst_cnt0", rd, 32'd0);
      readReg(A_STATUS, rd); checkOutput("arst_status", rd, 32'd0);
      readReg(A_CTRL1, rd);  checkOutput("arst_ctrl1", rd, 32'd0);
      readReg(A_PRE0, rd);   checkOutput("arst_pre0", rd, 32'd0);
      step();
      RST_I = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
